// File: rtl/bit_reversal_count.sv
// Ping-pong reorder buffer: natural-order frames in, bit-reversed frames out.
// Two-cycle read latency (address register, then data/output register).
module bit_reversal_count #(
  parameter int I_BW   = 14,
  parameter int O_BW   = 14,
  parameter int N      = 1024,
  parameter int IDX_BW = 10,
  parameter int GN_BW  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     di_en,
  input  logic signed [I_BW-1:0]   data_i,
  input  logic        [GN_BW-1:0]  in_group_num,
  input  logic        [IDX_BW-1:0] in_group_idx,
  output logic                     do_en,
  output logic signed [O_BW-1:0]   data_o,
  output logic        [GN_BW-1:0]  out_group_num,
  output logic        [IDX_BW-1:0] out_group_idx
);

  localparam logic [IDX_BW-1:0] LastIdx = IDX_BW'(N - 1);

  function automatic logic [IDX_BW-1:0] f_bitrev(
    input logic [IDX_BW-1:0] a
  );
    logic [IDX_BW-1:0] r;
    for (int i = 0; i < IDX_BW; i++) begin
      r[i] = a[IDX_BW-1-i];
    end
    return r;
  endfunction

  logic [I_BW-1:0] r_mem0 [N];
  logic [I_BW-1:0] r_mem1 [N];

  logic [1:0]        r_full;
  logic [GN_BW-1:0]  r_gn [2];

  logic              r_a_vld;
  logic              r_a_bank;
  logic [IDX_BW-1:0] r_a_k;
  logic [IDX_BW-1:0] r_addr;
  logic [GN_BW-1:0]  r_a_gn;

  logic              w_wbank;
  logic              w_done_in;
  logic              w_a_last;
  logic              w_start;
  logic              w_sbank;
  logic [1:0]        w_busy;
  logic [IDX_BW-1:0] w_k_nxt;
  logic signed [I_BW-1:0] w_rd;
  logic signed [O_BW-1:0] w_ext;

  assign w_wbank   = in_group_num[0];
  assign w_done_in = di_en && (in_group_idx == LastIdx);
  assign w_a_last  = r_a_vld && (r_a_k == LastIdx);
  assign w_k_nxt   = r_a_k + 1'b1;

  // Reader takes a new bank when idle or on its last address cycle;
  // when finishing, the other bank follows without a gap.
  always_comb begin
    w_start = 1'b0;
    w_sbank = 1'b0;
    if (!r_a_vld) begin
      w_start = |r_full;
      w_sbank = !r_full[0];
    end else if (w_a_last) begin
      w_sbank = !r_a_bank;
      w_start = r_full[!r_a_bank];
    end
  end

  always_comb begin
    w_busy = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (r_a_vld && (r_a_bank == 1'(b))) begin
        w_busy[b] = 1'b1;
      end
      if (w_start && (w_sbank == 1'(b))) begin
        w_busy[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (di_en) begin
      if (w_wbank) begin
        r_mem1[in_group_idx] <= data_i;
      end else begin
        r_mem0[in_group_idx] <= data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
      r_gn[0] <= '0;
      r_gn[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_start && (w_sbank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
        // A completion landing on a bank under readout is dropped.
        if (w_done_in && (w_wbank == 1'(b)) && !w_busy[b]) begin
          r_full[b] <= 1'b1;
          r_gn[b]   <= in_group_num;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_vld  <= 1'b0;
      r_a_bank <= 1'b0;
      r_a_k    <= '0;
      r_addr   <= '0;
      r_a_gn   <= '0;
    end else if (w_start) begin
      r_a_vld  <= 1'b1;
      r_a_bank <= w_sbank;
      r_a_k    <= '0;
      r_addr   <= '0;
      r_a_gn   <= r_gn[w_sbank];
    end else if (w_a_last) begin
      r_a_vld  <= 1'b0;
    end else if (r_a_vld) begin
      r_a_k    <= w_k_nxt;
      r_addr   <= f_bitrev(w_k_nxt);
    end
  end

  assign w_rd  = r_a_bank ? r_mem1[r_addr] : r_mem0[r_addr];
  assign w_ext = O_BW'(w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_num <= '0;
      out_group_idx <= '0;
    end else begin
      do_en <= r_a_vld;
      if (r_a_vld) begin
        data_o        <= w_ext;
        out_group_num <= r_a_gn;
        out_group_idx <= r_a_k;
      end
    end
  end

endmodule

// File: tb/tb_bit_reversal_count.sv
// Directed bench for bit_reversal_count: timing, ordering, banks, reset.
module tb_bit_reversal_count;

  localparam int N = 1024;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               di_en = 1'b0;
  logic signed [13:0] data_i = '0;
  logic        [6:0]  in_group_num = '0;
  logic        [9:0]  in_group_idx = '0;
  logic               do_en;
  logic signed [13:0] data_o;
  logic        [6:0]  out_group_num;
  logic        [9:0]  out_group_idx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e_of [128];

  logic [13:0] cap_d [3*N];
  logic [6:0]  cap_g [3*N];
  logic [9:0]  cap_i [3*N];
  logic        cap_e [3*N];
  int          cap_rise;
  logic        cap_after;

  bit_reversal_count dut (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
    .in_group_num(in_group_num), .in_group_idx(in_group_idx),
    .do_en(do_en), .data_o(data_o),
    .out_group_num(out_group_num), .out_group_idx(out_group_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] brev(input int k);
    logic [9:0] a;
    logic [9:0] r;
    a = 10'(k);
    for (int i = 0; i < 10; i++) r[i] = a[9-i];
    return r;
  endfunction

  // mode 0: constant 100, 1: ramp, 2: frame-tagged ramp
  task automatic drive_frame(input int gn, input int mode,
                             input bit sparse, input int last);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      di_en = 1'b1;
      in_group_num = 7'(gn);
      in_group_idx = 10'(i);
      case (mode)
        0: data_i = 14'sd100;
        1: data_i = 14'(i);
        default: data_i = 14'((gn % 8) * 1024 + i);
      endcase
      if (i == N - 1) e_of[gn] = cyc + 1;
      if (sparse) begin
        @(negedge clk);
        di_en = 1'b0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    di_en = 1'b0;
  endtask

  task automatic capture(input int nf);
    int t;
    t = 0;
    cap_rise = -1;
    @(posedge clk); #1;
    while (!do_en && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (do_en) begin
      cap_rise = cyc;
      for (int j = 0; j < nf * N; j++) begin
        cap_e[j] = do_en;
        cap_d[j] = data_o;
        cap_g[j] = out_group_num;
        cap_i[j] = out_group_idx;
        @(posedge clk); #1;
      end
      cap_after = do_en;
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({do_en, data_o, out_group_num, out_group_idx} !== '0) begin
      fails++;
      $display("FAIL reset_vals got en=%b d=%0d g=%0d i=%0d exp all 0",
               do_en, data_o, out_group_num, out_group_idx);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    begin
      int hi;
      hi = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (do_en) hi++;
      end
      tests++;
      if (hi !== 0) begin
        fails++;
        $display("FAIL idle_after_reset got %0d valid cycles exp 0", hi);
      end
    end
  endtask

  task automatic test_const();
    fork
      begin
        drive_frame(0, 0, 0, N - 1);
        drive_frame(1, 0, 0, N - 1);
        idle();
      end
      capture(2);
    join
    tests++;
    if (cap_rise !== e_of[0] + 2) begin
      fails++;
      $display("FAIL const_rise got %0d exp %0d", cap_rise, e_of[0] + 2);
    end
    if (cap_rise >= 0) begin
      for (int j = 0; j < 2 * N; j++) begin
        tests++;
        if ({cap_e[j], cap_d[j], cap_g[j], cap_i[j]} !==
            {1'b1, 14'd100, 7'(j / N), 10'(j % N)}) begin
          fails++;
          $display("FAIL const_s%0d got en=%b d=%0d g=%0d i=%0d exp 1/100/%0d/%0d",
                   j, cap_e[j], cap_d[j], cap_g[j], cap_i[j], j / N, j % N);
        end
      end
      tests++;
      if (cap_after !== 1'b0) begin
        fails++;
        $display("FAIL const_end got en=%b exp 0", cap_after);
      end
    end
  endtask

  task automatic test_ramp(input int gn, input bit sparse);
    logic [13:0] hv [5];
    int          hk [5];
    hv = '{14'd0, 14'd512, 14'd256, 14'd768, 14'd1023};
    hk = '{0, 1, 2, 3, 1023};
    fork
      begin
        drive_frame(gn, 1, sparse, N - 1);
        idle();
      end
      capture(1);
    join
    tests++;
    if (cap_rise !== e_of[gn] + 2) begin
      fails++;
      $display("FAIL ramp%0d_rise got %0d exp %0d", gn, cap_rise, e_of[gn] + 2);
    end
    if (cap_rise >= 0) begin
      for (int h = 0; h < 5; h++) begin
        tests++;
        if (cap_d[hk[h]] !== hv[h]) begin
          fails++;
          $display("FAIL ramp%0d_k%0d got %0d exp %0d",
                   gn, hk[h], cap_d[hk[h]], hv[h]);
        end
      end
      for (int j = 0; j < N; j++) begin
        tests++;
        if ({cap_e[j], cap_d[j], cap_g[j], cap_i[j]} !==
            {1'b1, 4'd0, brev(j), 7'(gn), 10'(j)}) begin
          fails++;
          $display("FAIL ramp%0d_s%0d got en=%b d=%0d g=%0d i=%0d exp d=%0d",
                   gn, j, cap_e[j], cap_d[j], cap_g[j], cap_i[j], brev(j));
        end
      end
      tests++;
      if (cap_after !== 1'b0) begin
        fails++;
        $display("FAIL ramp%0d_end got en=%b exp 0", gn, cap_after);
      end
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        drive_frame(5, 2, 0, N - 1);
        drive_frame(6, 2, 0, N - 1);
        drive_frame(7, 2, 0, N - 1);
        idle();
      end
      capture(3);
    join
    tests++;
    if (cap_rise !== e_of[5] + 2) begin
      fails++;
      $display("FAIL b2b_rise got %0d exp %0d", cap_rise, e_of[5] + 2);
    end
    if (cap_rise >= 0) begin
      for (int j = 0; j < 3 * N; j++) begin
        int g;
        g = 5 + j / N;
        tests++;
        if ({cap_e[j], cap_d[j], cap_g[j], cap_i[j]} !==
            {1'b1, 14'((g % 8) * 1024 + brev(j % N)), 7'(g), 10'(j % N)}) begin
          fails++;
          $display("FAIL b2b_s%0d got en=%b d=%0d g=%0d i=%0d exp g=%0d i=%0d",
                   j, cap_e[j], cap_d[j], cap_g[j], cap_i[j], g, j % N);
        end
      end
      tests++;
      if (cap_after !== 1'b0) begin
        fails++;
        $display("FAIL b2b_end got en=%b exp 0", cap_after);
      end
    end
  endtask

  task automatic test_incomplete();
    int hi;
    hi = 0;
    fork
      begin
        drive_frame(8, 1, 0, 500);
        idle();
      end
      repeat (1600) begin
        @(posedge clk); #1;
        if (do_en) hi++;
      end
    join
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL incomplete got %0d valid cycles exp 0", hi);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int hi;
    t = 0;
    hi = 0;
    fork
      begin
        drive_frame(9, 1, 0, N - 1);
        idle();
      end
      begin
        while (!do_en && t < 3000) begin
          @(posedge clk); #1;
          t++;
        end
        tests++;
        if (do_en !== 1'b1) begin
          fails++;
          $display("FAIL rstmid_start got en=%b exp 1", do_en);
        end
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({do_en, data_o, out_group_num, out_group_idx} !== '0) begin
          fails++;
          $display("FAIL rstmid_vals got en=%b d=%0d g=%0d i=%0d exp all 0",
                   do_en, data_o, out_group_num, out_group_idx);
        end
      end
    join
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (do_en) hi++;
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL rstmid_quiet got %0d valid cycles exp 0", hi);
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ramp(2, 1'b0);
    test_ramp(3, 1'b1);
    test_back_to_back();
    test_incomplete();
    test_reset_mid();
    test_ramp(10, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
